// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate-sweep checker and its stimulus side.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int MAX_LAT  = 7;
   localparam int MAX_N_IN = 16;

   // Callers pad unused high bits with ones so narrower vectors reduce correctly.
   function automatic logic exp_and(input logic [MAX_N_IN-1:0] vec);
      return &vec;
   endfunction

endpackage

// File: rtl/vec_delay_line.sv
// Delays a {valid, vector} pair by DEPTH cycles; DEPTH=0 is a straight wire.
module vec_delay_line #(
   parameter int W     = 4,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_vld,
   input  logic [W-1:0] in_vec,
   output logic         out_vld,
   output logic [W-1:0] out_vec
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ok_s;
         assign unused_ok_s = ^{clk, rst_n, clr};
         assign out_vld     = in_vld;
         assign out_vec     = in_vec;
      end else begin : g_pipe
         logic [W:0] stage_q [DEPTH];
         logic [W:0] stage_d [DEPTH];

         // Shift stages, flushing every stage on clr.
         always_comb begin
            if (clr) begin
               stage_d[0] = {(W+1){1'b0}};
            end else begin
               stage_d[0] = {in_vld, in_vec};
            end
            for (int i = 1; i < DEPTH; i++) begin
               if (clr) begin
                  stage_d[i] = {(W+1){1'b0}};
               end else begin
                  stage_d[i] = stage_q[i-1];
               end
            end
         end

         // Stage registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= {(W+1){1'b0}};
               end
            end else begin
               stage_q <= stage_d;
            end
         end

         assign out_vld = stage_q[DEPTH-1][W];
         assign out_vec = stage_q[DEPTH-1][W-1:0];
      end
   endgenerate

endmodule

// File: rtl/gate_sweep_checker.sv
// Response checker for exhaustive N-input AND sweeps: aligns stimulus with y,
// counts mismatches, tracks vector coverage and reports pass at sweep end.
module gate_sweep_checker
   import gate_chk_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int LAT   = 1,
   parameter int ERR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  in_vld,
   input  logic [N_IN-1:0]       in_vec,
   input  logic                  y,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_cnt,
   output logic [(1<<N_IN)-1:0]  cov,
   output logic [N_IN-1:0]       first_err_vec,
   output logic                  first_err_vld
);

   localparam int               COV_W      = 1 << N_IN;
   localparam logic [2:0]       DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
   localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

   state_e            state_q, state_d;
   logic [2:0]        drain_q, drain_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [COV_W-1:0]  cov_q, cov_d;
   logic [N_IN-1:0]   fev_q, fev_d;
   logic              fevld_q, fevld_d;

   logic                dl_clr_s;
   logic                dl_in_vld_s;
   logic                dl_out_vld_s;
   logic [N_IN-1:0]     dl_out_vec_s;
   logic [MAX_N_IN-1:0] chk_pad_s;
   logic                chk_en_s;
   logic                mismatch_s;
   logic                err_inc_s;
   logic                capture_s;
   logic [COV_W-1:0]    cov_hit_s;

   vec_delay_line #(
      .W     (N_IN),
      .DEPTH (LAT)
   ) u_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (dl_clr_s),
      .in_vld  (dl_in_vld_s),
      .in_vec  (in_vec),
      .out_vld (dl_out_vld_s),
      .out_vec (dl_out_vec_s)
   );

   // Sweep FSM, check of the aligned vector against y, and result bookkeeping.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      err_d       = err_q;
      cov_d       = cov_q;
      fev_d       = fev_q;
      fevld_d     = fevld_q;
      pass_d      = pass_q;
      dl_clr_s    = 1'b0;
      dl_in_vld_s = 1'b0;

      chk_pad_s              = {MAX_N_IN{1'b1}};
      chk_pad_s[N_IN-1:0]    = dl_out_vec_s;
      chk_en_s   = dl_out_vld_s && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
      mismatch_s = chk_en_s && (y != exp_and(chk_pad_s));
      capture_s  = mismatch_s && !fevld_q;
      err_inc_s  = mismatch_s && (err_q != ERR_MAX);
      cov_hit_s  = chk_en_s ? (COV_W'(1) << dl_out_vec_s) : {COV_W{1'b0}};

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               dl_clr_s = 1'b1;
               err_d    = {ERR_W{1'b0}};
               cov_d    = {COV_W{1'b0}};
               fev_d    = {N_IN{1'b0}};
               fevld_d  = 1'b0;
               pass_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            dl_in_vld_s = in_vld;
            if (stop) begin
               if (LAT == 0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_INIT;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_q == 3'd0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
               drain_d = drain_q - 3'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Checks never coincide with the IDLE clear, so these merge cleanly.
      cov_d   = cov_d | cov_hit_s;
      err_d   = err_d + ERR_W'(err_inc_s);
      fev_d   = capture_s ? dl_out_vec_s : fev_d;
      fevld_d = fevld_d | capture_s;

      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
      pass_d = done_d ? ((err_d == {ERR_W{1'b0}}) && (&cov_d)) : pass_d;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         drain_q <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= {ERR_W{1'b0}};
         cov_q   <= {COV_W{1'b0}};
         fev_q   <= {N_IN{1'b0}};
         fevld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         cov_q   <= cov_d;
         fev_q   <= fev_d;
         fevld_q <= fevld_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_q;
   assign cov           = cov_q;
   assign first_err_vec = fev_q;
   assign first_err_vld = fevld_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized bench: three checkers (LAT 1/0/3) see the same sweeps; a sweep-level
// model derives expected results from the recorded vectors and y values.
module tb_gate_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, in_vld;
   logic [3:0] in_vec;
   logic [2:0] y_w, busy_w, done_w, pass_w, fevld_w;
   logic [7:0] err0_w, err1_w;
   logic [1:0] err2_w;
   logic [15:0] cov_w [3];
   logic [3:0]  fev_w [3];

   always #5 clk = ~clk;

   gate_sweep_checker #(.N_IN(4), .LAT(1), .ERR_W(8)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_vld(in_vld),
      .in_vec(in_vec), .y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_cnt(err0_w), .cov(cov_w[0]), .first_err_vec(fev_w[0]), .first_err_vld(fevld_w[0]));

   gate_sweep_checker #(.N_IN(4), .LAT(0), .ERR_W(8)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_vld(in_vld),
      .in_vec(in_vec), .y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_cnt(err1_w), .cov(cov_w[1]), .first_err_vec(fev_w[1]), .first_err_vld(fevld_w[1]));

   gate_sweep_checker #(.N_IN(4), .LAT(3), .ERR_W(2)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_vld(in_vld),
      .in_vec(in_vec), .y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
      .err_cnt(err2_w), .cov(cov_w[2]), .first_err_vec(fev_w[2]), .first_err_vld(fevld_w[2]));

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         phase = 0;      // 0 idle, 1 accepting, 2 after stop
   int         stop_edge = 0;
   int         mode [3];       // 0 correct AND, 1 stuck-0, 2 stuck-1, 3 random
   int         acc_q [$];
   logic [3:0] sweep_q [$];
   bit         seen [3];
   int         seen_edge [3];
   logic [3:0] vec_hist [0:8191];
   bit         acc_hist [0:8191];
   bit [2:0]   y_hist   [0:8191];

   function automatic int lat_of(input int i);
      case (i)
         0: return 1;
         1: return 0;
         default: return 3;
      endcase
   endfunction

   function automatic int errmax_of(input int i);
      return (i == 2) ? 3 : 255;
   endfunction

   function automatic int get_err(input int i);
      case (i)
         0: return int'(err0_w);
         1: return int'(err1_w);
         default: return int'(err2_w);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive inputs and y at negedge, record history, advance to next negedge.
   task automatic drive_cycle(input bit st, input bit sp, input bit iv, input logic [3:0] v);
      int e;
      int idx;
      bit acc;
      bit yb;
      e      = cyc + 1;
      start  = st;
      stop   = sp;
      in_vld = iv;
      in_vec = v;
      acc    = (phase == 1) && iv;
      acc_hist[e] = acc;
      vec_hist[e] = v;
      if (acc) acc_q.push_back(e);
      for (int i = 0; i < 3; i++) begin
         case (mode[i])
            0: begin
               idx = e - lat_of(i);
               if (idx >= 0 && acc_hist[idx]) yb = (vec_hist[idx] == 4'hF);
               else yb = 1'($urandom);
            end
            1: yb = 1'b0;
            2: yb = 1'b1;
            default: yb = 1'($urandom);
         endcase
         y_hist[e][i] = yb;
         y_w[i] = yb;
      end
      if (phase == 0 && st) phase = 1;
      else if (phase == 1 && sp) begin
         phase = 2;
         stop_edge = e;
      end
      @(posedge clk);
      cyc = e;
      @(negedge clk);
   endtask

   task automatic check_results(input int i);
      int         mism = 0;
      int         ed;
      int         exp_err;
      bit         fv = 1'b0;
      logic [3:0] fvec = 4'h0;
      logic [3:0] v;
      logic [15:0] c = 16'h0;
      for (int k = 0; k < acc_q.size(); k++) begin
         ed = acc_q[k];
         v  = vec_hist[ed];
         c[v] = 1'b1;
         if (y_hist[ed + lat_of(i)][i] != (v == 4'hF)) begin
            mism++;
            if (!fv) begin
               fv = 1'b1;
               fvec = v;
            end
         end
      end
      exp_err = (mism > errmax_of(i)) ? errmax_of(i) : mism;
      chk($sformatf("u%0d_err_cnt", i), get_err(i), exp_err);
      chk($sformatf("u%0d_cov", i), cov_w[i], c);
      chk($sformatf("u%0d_first_err_vld", i), fevld_w[i], fv);
      chk($sformatf("u%0d_first_err_vec", i), fev_w[i], fvec);
      chk($sformatf("u%0d_pass", i), pass_w[i], (exp_err == 0) && (c == 16'hFFFF));
   endtask

   task automatic check_done();
      for (int i = 0; i < 3; i++) begin
         if (!seen[i]) begin
            if (done_w[i]) begin
               seen[i] = 1'b1;
               seen_edge[i] = cyc;
               chk($sformatf("u%0d_done_time", i), cyc, stop_edge + lat_of(i));
               chk($sformatf("u%0d_busy_at_done", i), busy_w[i], 1'b0);
               check_results(i);
            end
         end else if (cyc == seen_edge[i] + 1) begin
            chk($sformatf("u%0d_done_pulse", i), done_w[i], 1'b0);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_u%0d_flags", tag, i),
             {busy_w[i], done_w[i], pass_w[i], fevld_w[i]}, 4'b0000);
         chk($sformatf("%s_u%0d_err", tag, i), get_err(i), 0);
         chk($sformatf("%s_u%0d_cov", tag, i), cov_w[i], 16'h0000);
         chk($sformatf("%s_u%0d_fev", tag, i), fev_w[i], 4'h0);
      end
   endtask

   task automatic run_sweep(input bit stop_with_last);
      int n;
      acc_q.delete();
      drive_cycle(1'b0, 1'b1, 1'b1, 4'($urandom));
      drive_cycle(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d_busy_after_start", i), busy_w[i], 1'b1);
         chk($sformatf("u%0d_cleared", i), {fevld_w[i], pass_w[i], cov_w[i]}, 18'h0);
      end
      n = sweep_q.size();
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 3) == 0) drive_cycle(1'($urandom), 1'b0, 1'b0, 4'($urandom));
         if (k == n - 1 && stop_with_last) drive_cycle(1'b0, 1'b1, 1'b1, sweep_q[k]);
         else drive_cycle(1'b0, 1'b0, 1'b1, sweep_q[k]);
      end
      if (!stop_with_last) drive_cycle(1'b0, 1'b1, 1'b0, 4'($urandom));
      for (int i = 0; i < 3; i++) seen[i] = 1'b0;
      check_done();
      for (int c = 0; c < 12; c++) begin
         drive_cycle(1'b0, 1'b0, 1'($urandom), 4'($urandom));
         check_done();
      end
      for (int i = 0; i < 3; i++) begin
         if (!seen[i]) chk($sformatf("u%0d_done_timeout", i), 32'd0, 32'd1);
      end
      phase = 0;
   endtask

   task automatic fill_ordered(input int count);
      sweep_q.delete();
      for (int k = 0; k < count; k++) sweep_q.push_back(4'(k));
   endtask

   task automatic set_modes(input int m);
      for (int i = 0; i < 3; i++) mode[i] = m;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] perm [16];
      logic [3:0] tmp;
      int         j;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_vld = 1'b0; in_vec = 4'h0; y_w = 3'b000;
      set_modes(0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 1'b0, 4'h0);
      check_zero("reset");
      rst_n = 1'b1;

      // Clean full sweep.
      fill_ordered(16); set_modes(0); run_sweep(1'b0);
      chk("clean_pass", pass_w, 3'b111);
      chk("clean_cov0", cov_w[0], 16'hFFFF);

      // y stuck-0: only vector F mismatches.
      set_modes(1); run_sweep(1'b0);
      chk("stuck0_err0", err0_w, 8'd1);
      chk("stuck0_fev1", fev_w[1], 4'hF);

      // y stuck-1, stop together with the last vector.
      set_modes(2); run_sweep(1'b1);
      chk("stuck1_err1", err1_w, 8'd15);
      chk("stuck1_sat2", err2_w, 2'd3);
      chk("stuck1_cov2", cov_w[2], 16'hFFFF);

      // Incomplete sweep.
      fill_ordered(15); set_modes(0); run_sweep(1'b0);
      chk("incomplete_cov0", cov_w[0], 16'h7FFF);
      chk("incomplete_pass", pass_w, 3'b000);

      // Randomized orders, gaps, drops, repeats and y behaviour.
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 16; k++) perm[k] = 4'(k);
         for (int k = 15; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
         end
         sweep_q.delete();
         for (int k = 0; k < 16; k++) begin
            if ((r % 2 == 1) && $urandom_range(0, 7) == 0) continue;
            sweep_q.push_back(perm[k]);
            if ($urandom_range(0, 7) == 0) sweep_q.push_back(perm[k]);
         end
         for (int i = 0; i < 3; i++) mode[i] = (r % 2 == 0) ? 0 : $urandom_range(0, 3);
         run_sweep(1'($urandom));
      end

      // Reset in the middle of a run, then a clean sweep.
      set_modes(2);
      acc_q.delete();
      drive_cycle(1'b1, 1'b0, 1'b0, 4'h0);
      for (int k = 0; k < 5; k++) drive_cycle(1'b0, 1'b0, 1'b1, 4'(k));
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      phase = 0;
      @(negedge clk);
      drive_cycle(1'b0, 1'b0, 1'b0, 4'h0);
      rst_n = 1'b1;
      fill_ordered(16); set_modes(0); run_sweep(1'b0);
      chk("after_reset_pass", pass_w, 3'b111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Response-side checker for exhaustive gate sweeps. It accepts the N_IN-bit stimulus vector driven to a combinational or pipelined N-input AND under test, aligns it with the DUT output `y`, and counts mismatches against the expected AND of the vector bits. It also records which input combinations were exercised and reports pass/fail at the end of the sweep. It sits opposite the binary-counter stimulus generator, on the same vector/`y` interface.

## Interface
- `N_IN`, default 4: vector width; coverage bitmap is 2^N_IN bits.
- `LAT`, default 1: DUT latency in cycles from vector accept to valid `y`; allowed range 0..7.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep (honoured only in IDLE).
- `stop`  in  1  last vector presented; begin drain.
- `in_vld`  in  1  `in_vec` valid this cycle.
- `in_vec`  in  N_IN  stimulus vector; bit0 is the fastest-toggling input.
- `y`  in  1  DUT output.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  result; valid from `done` until the next `start`.
- `err_cnt`  out  ERR_W  saturating mismatch count.
- `cov`  out  2^N_IN  bit i set once vector i has been checked.
- `first_err_vec`  out  N_IN  vector of the first mismatch.
- `first_err_vld`  out  1  `first_err_vec` is meaningful.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - On `start`, clear `err_cnt`, `cov`, `first_err_*`, `pass` and the delay line, then go to RUN.
  - `stop` and `in_vld` are ignored in IDLE.
- **RUN:**
  - Each cycle with `in_vld` pushes `in_vec` into the LAT-deep delay line.
  - When the line outputs a valid vector `v`, compare `y` against `&v`.
  - On mismatch, increment `err_cnt`, saturating at 2^ERR_W−1. If `first_err_vld` is 0, capture `v` into `first_err_vec` and set `first_err_vld`.
  - Set `cov[v]` for every checked vector, whether it matched or not.
  - On `stop`, go to DRAIN. If `in_vld` is high in the same cycle, that vector is still accepted.
  - `start` is ignored in RUN.
- **DRAIN:**
  - Lasts exactly LAT cycles. `in_vld` is ignored; in-flight vectors are still checked.
  - Then go to DONE.
  - If LAT=0, skip DRAIN: RUN goes straight to DONE.
- **DONE:**
  - Lasts one cycle with `done`=1.
  - `pass` is set to (`err_cnt`==0 && `cov` all ones), using the values after the final check.
  - Then go to IDLE. All results hold until the next `start`.
- **Vector repeats:** a repeated vector is re-checked; `cov` is idempotent.

## Timing
- All outputs are registered.
- **Reset values:**
  - `busy`, `done`, `pass`, `first_err_vld`: 0.
  - `err_cnt`, `cov`, `first_err_vec`: 0.
  - FSM in IDLE; delay line empty.
- **Check alignment:**
  - A vector accepted at edge k is checked against `y` sampled at edge k+LAT.
  - For LAT=0, `y` is sampled at the same edge as `in_vld`.
  - Counter and bitmap updates are visible after that edge.
- **Start latency:** `busy` rises the cycle after the `start` edge.
- **Done timing:**
  - With `stop` sampled at edge T, `done` is high during cycle T+LAT+1.
  - `busy` falls at the same edge that `done` rises.
- **Reset mid-operation:** `rst_n` low in any state immediately forces all reset values and discards in-flight vectors.

## Structure
- **Package `gate_chk_pkg`:**
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - `MAX_LAT`=7.
  - Function `exp_and(vec)` returning the reduction AND, shared with the stimulus side.
- **Sub-module `vec_delay_line`:**
  - Parameters `W`, `DEPTH`; shifts {valid, vec} by DEPTH cycles.
  - `DEPTH`=0 is a pass-through.
  - Flushes on reset and on a `clr` input.

## Test plan
- **Clean sweep:** LAT=1, correct AND DUT, vectors 0..15 one per cycle, then `stop` → `done` two cycles after `stop`, `err_cnt`=0, `cov`=16'hFFFF, `pass`=1.
- **y stuck-0:** LAT=1, full sweep → `err_cnt`=1, `first_err_vec`=4'hF, `first_err_vld`=1, `pass`=0.
- **y stuck-1:** LAT=0, full sweep → `err_cnt`=15, `first_err_vec`=4'h0, `done` one cycle after `stop`, `pass`=0.
- **Incomplete sweep:** vectors 0..14 only → `err_cnt`=0, `cov`=16'h7FFF, `pass`=0.
- **Saturation:** ERR_W=2 with y stuck-1 → `err_cnt` saturates at 3; `stop` together with `in_vld` on vector 15 → vector 15 still checked, `cov[15]`=1.
- **Reset mid-run:** `rst_n` low after 5 vectors → all outputs 0 and `busy` 0 immediately; a fresh `start` then a clean sweep gives `pass`=1.
